// File: rtl/midi_pkg.sv
// Shared MIDI transmitter definitions: line rate, byte width and serializer states.
package midi_pkg;

  localparam int MIDI_BAUD       = 31250;
  localparam int MIDI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/fifo.sv
// Show-ahead FIFO with an occupancy counter so full/empty never alias at count=depth.
// Used single-clock here, with wr_clk and rd_clk tied to the same clock.
module fifo #(
  parameter int FIFO_DATA_WIDTH  = 8,
  parameter int FIFO_BUFFER_SIZE = 4
) (
  input  logic                       wr_clk,
  input  logic                       rd_clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] wr_data,
  input  logic                       rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] rd_data,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(FIFO_BUFFER_SIZE);
  localparam int CNT_W = $clog2(FIFO_BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_BUFFER_SIZE);

  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       push;
  logic                       pop;

  // A full buffer refuses the write even when a read frees a slot that same cycle.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_ff @(posedge wr_clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);

endmodule

// File: rtl/midi_tx.sv
// Buffered MIDI 8N1 transmitter: queued bytes are serialized LSB first, and
// a stop bit runs straight into the next start bit when more data is waiting.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = MIDI_BAUD,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MIDI_DATA_WIDTH-1:0] din,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       dout,
  output logic                       busy
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int CNT_W      = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  tx_state_t                  state;
  tx_state_t                  state_next;
  logic [CNT_W-1:0]           baud_cnt;
  logic [2:0]                 bit_idx;
  logic [MIDI_DATA_WIDTH-1:0] shreg;
  logic [MIDI_DATA_WIDTH-1:0] fifo_rd_data;
  logic                       fifo_empty;
  logic                       pop;
  logic                       bit_end;

  fifo #(
    .FIFO_DATA_WIDTH (MIDI_DATA_WIDTH),
    .FIFO_BUFFER_SIZE(FIFO_DEPTH)
  ) u_fifo (
    .wr_clk (clk),
    .rd_clk (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(din),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (full),
    .empty  (fifo_empty)
  );

  assign bit_end = (baud_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The bit timer restarts on every boundary so period errors never accumulate.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      if (pop) begin
        shreg <= fifo_rd_data;
      end else if (state == DATA && bit_end) begin
        shreg <= {1'b0, shreg[MIDI_DATA_WIDTH-1:1]};
      end
      if (state == IDLE || bit_end) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout <= 1'b1;
      busy <= 1'b0;
    end else begin
      case (state)
        START:   dout <= 1'b0;
        DATA:    dout <= shreg[0];
        default: dout <= 1'b1;
      endcase
      busy <= (state != IDLE) || !fifo_empty;
    end
  end

endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx at 10 clocks per bit: records the line per cycle
// and checks frame timing and decoded bytes against hand-computed values.
module tb_midi_tx;

  localparam int CLK_FREQ   = 100;
  localparam int BAUD       = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int WIN        = 600;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       full;
  logic       dout;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic       line_s    [WIN];
  logic       busy_s    [WIN];
  logic       full_s    [WIN];
  logic       wr_sched  [WIN];
  logic [7:0] din_sched [WIN];
  logic       rst_sched [WIN];
  logic [7:0] rx_bytes  [8];
  int         rx_count;

  midi_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .wr_en(wr_en),
    .full (full),
    .dout (dout),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_sched();
    for (int i = 0; i < WIN; i++) begin
      wr_sched[i]  = 1'b0;
      din_sched[i] = 8'h00;
      rst_sched[i] = 1'b0;
    end
  endtask

  // Sample index i holds outputs after the rising edge preceding negedge i;
  // inputs scheduled at i are taken by the following rising edge.
  task automatic run_window(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      line_s[i] = dout;
      busy_s[i] = busy;
      full_s[i] = full;
      wr_en     = wr_sched[i];
      din       = din_sched[i];
      reset     = rst_sched[i];
    end
    wr_en = 1'b0;
    reset = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return b[p-1];
  endfunction

  function automatic int period_errors(input int s, input logic [7:0] b, input int p);
    int e = 0;
    for (int k = 0; k < 10; k++) begin
      if (line_s[s + 10*p + k] !== exp_bit(b, p)) e++;
    end
    return e;
  endfunction

  function automatic int frame_errors(input int s, input logic [7:0] b);
    int e = 0;
    for (int p = 0; p < 10; p++) e += period_errors(s, b, p);
    return e;
  endfunction

  task automatic find_frame(input int from, input int n, output int st, output logic [7:0] d);
    st = -1;
    d  = 8'h00;
    for (int i = from; i + 95 < n; i++) begin
      if (st < 0 && line_s[i-1] === 1'b1 && line_s[i] === 1'b0) begin
        st = i;
        for (int b = 0; b < 8; b++) d[b] = line_s[i + 10*(b+1) + 5];
      end
    end
  endtask

  task automatic receive_all(input int n);
    int pos;
    int st;
    logic [7:0] d;
    pos      = 1;
    rx_count = 0;
    for (int k = 0; k < 8; k++) begin
      find_frame(pos, n, st, d);
      if (st < 0) break;
      rx_bytes[k] = d;
      rx_count++;
      pos = st + 95;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0;
    din   = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 1'b1) begin errors++; $display("[TB] FAIL reset_dout: got %b expected 1", dout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
    wr_en = 1'b1;
    din   = 8'hAA;
    @(negedge clk);
    reset = 1'b0;
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_write_ignored_busy: got %b expected 0", busy); end
    checks++; if (dout !== 1'b1) begin errors++; $display("[TB] FAIL reset_write_ignored_dout: got %b expected 1", dout); end
  endtask

  task automatic test_single_frame();
    int e;
    clear_sched();
    wr_sched[2] = 1'b1; din_sched[2] = 8'h90;
    run_window(120);
    checks++; if (line_s[4] !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_before: got %b expected 1", line_s[4]); end
    for (int p = 0; p < 10; p++) begin
      e = period_errors(5, 8'h90, p);
      checks++; if (e !== 0) begin errors++; $display("[TB] FAIL single_period%0d: got %0d wrong samples expected 0", p, e); end
    end
    checks++; if (line_s[105] !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_after: got %b expected 1", line_s[105]); end
    checks++; if (busy_s[3] !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_pre: got %b expected 0", busy_s[3]); end
    checks++; if (busy_s[4] !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_rise: got %b expected 1", busy_s[4]); end
    checks++; if (busy_s[104] !== 1'b1) begin errors++; $display("[TB] FAIL single_busy_stop: got %b expected 1", busy_s[104]); end
    checks++; if (busy_s[105] !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_fall: got %b expected 0", busy_s[105]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int e;
    bytes[0] = 8'h90; bytes[1] = 8'h3C; bytes[2] = 8'h7F;
    clear_sched();
    for (int k = 0; k < 3; k++) begin
      wr_sched[2+k] = 1'b1; din_sched[2+k] = bytes[k];
    end
    run_window(330);
    for (int k = 0; k < 3; k++) begin
      e = frame_errors(5 + 100*k, bytes[k]);
      checks++; if (e !== 0) begin errors++; $display("[TB] FAIL b2b_frame%0d: got %0d wrong samples expected 0", k, e); end
    end
    receive_all(330);
    checks++; if (rx_count !== 3) begin errors++; $display("[TB] FAIL b2b_rx_count: got %0d expected 3", rx_count); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rx_bytes[k] !== bytes[k]) begin errors++; $display("[TB] FAIL b2b_rx%0d: got %h expected %h", k, rx_bytes[k], bytes[k]); end
    end
    checks++; if (busy_s[304] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy_last: got %b expected 1", busy_s[304]); end
    checks++; if (busy_s[305] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_fall: got %b expected 0", busy_s[305]); end
  endtask

  task automatic test_overflow();
    clear_sched();
    for (int k = 0; k < 6; k++) begin
      wr_sched[2+k] = 1'b1; din_sched[2+k] = 8'(k + 1);
    end
    run_window(560);
    checks++; if (full_s[6] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_4th: got %b expected 0", full_s[6]); end
    checks++; if (full_s[7] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_5th: got %b expected 1", full_s[7]); end
    checks++; if (full_s[8] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_6th: got %b expected 1", full_s[8]); end
    checks++; if (full_s[103] !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full_hold: got %b expected 1", full_s[103]); end
    checks++; if (full_s[104] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_full_release: got %b expected 0", full_s[104]); end
    receive_all(560);
    checks++; if (rx_count !== 5) begin errors++; $display("[TB] FAIL ovf_rx_count: got %0d expected 5", rx_count); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (rx_bytes[k] !== 8'(k + 1)) begin errors++; $display("[TB] FAIL ovf_rx%0d: got %h expected %h", k, rx_bytes[k], 8'(k + 1)); end
    end
    checks++; if (busy_s[505] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_busy_fall: got %b expected 0", busy_s[505]); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    int e;
    clear_sched();
    wr_sched[2] = 1'b1; din_sched[2] = 8'hFF;
    wr_sched[3] = 1'b1; din_sched[3] = 8'h11;
    rst_sched[39] = 1'b1;
    run_window(200);
    checks++; if (busy_s[39] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_before: got %b expected 1", busy_s[39]); end
    checks++; if (busy_s[40] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy_after: got %b expected 0", busy_s[40]); end
    bad = 0;
    for (int i = 40; i < 200; i++) begin
      if (line_s[i] !== 1'b1 || busy_s[i] !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rstmid_quiet: got %0d active samples expected 0", bad); end
    clear_sched();
    wr_sched[2] = 1'b1; din_sched[2] = 8'h55;
    run_window(120);
    e = frame_errors(5, 8'h55);
    checks++; if (e !== 0) begin errors++; $display("[TB] FAIL rstmid_clean_frame: got %0d wrong samples expected 0", e); end
    receive_all(120);
    checks++; if (rx_count !== 1 || rx_bytes[0] !== 8'h55) begin errors++; $display("[TB] FAIL rstmid_rx: got count %0d byte %h expected count 1 byte 55", rx_count, rx_bytes[0]); end
  endtask

  task automatic test_extremes();
    int run;
    int e;
    clear_sched();
    wr_sched[2] = 1'b1; din_sched[2] = 8'h00;
    wr_sched[3] = 1'b1; din_sched[3] = 8'hFF;
    run_window(220);
    run = 0;
    for (int i = 5; i < 220 && line_s[i] === 1'b0; i++) run++;
    checks++; if (run !== 90) begin errors++; $display("[TB] FAIL ext_zero_low_run: got %0d expected 90", run); end
    run = 0;
    for (int i = 105; i < 220 && line_s[i] === 1'b0; i++) run++;
    checks++; if (run !== 10) begin errors++; $display("[TB] FAIL ext_ff_low_run: got %0d expected 10", run); end
    e = frame_errors(5, 8'h00);
    checks++; if (e !== 0) begin errors++; $display("[TB] FAIL ext_frame00: got %0d wrong samples expected 0", e); end
    e = frame_errors(105, 8'hFF);
    checks++; if (e !== 0) begin errors++; $display("[TB] FAIL ext_frameFF: got %0d wrong samples expected 0", e); end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    din   = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_extremes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
MIDI_TX -- requirements
Module: midi_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 31250, MIDI serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, transmit buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din  input  8  MIDI byte to transmit.
REQ-007 SHALL have port wr_en  input  1  write strobe for din.
REQ-008 SHALL have port full  output  1  buffer holds FIFO_DEPTH bytes; writes are dropped.
REQ-009 SHALL have port dout  output  1  serial MIDI line, idle high, registered.
REQ-010 SHALL have port busy  output  1  frame in progress or buffer non-empty.

Function
REQ-011 SHALL use BIT_CYCLES = CLK_FREQ/BAUD (integer division); 1600 at the defaults.
REQ-012 SHALL push din into the FIFO on any cycle where wr_en=1 and full=0.
REQ-013 SHALL silently drop a write when full=1, including on a cycle where a pop also occurs.
REQ-014 SHALL derive full and empty from a registered occupancy count (0..FIFO_DEPTH), with no wrap aliasing at count=FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: dout=1; when the FIFO is non-empty, pop one byte into a shift register and go to START.
REQ-017 START: dout=0 for BIT_CYCLES cycles, then go to DATA.
REQ-018 DATA: send 8 bits LSB first, each held BIT_CYCLES cycles; a 3-bit counter selects the bit; after bit 7, go to STOP.
REQ-019 STOP: dout=1 for BIT_CYCLES cycles; if the FIFO is then non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-020 SHALL make each frame exactly 10*BIT_CYCLES cycles (8N1, no parity).
REQ-021 Latency: a write on cycle N into an empty FIFO with the FSM in IDLE SHALL drive dout low from cycle N+2.
REQ-022 SHALL reload the bit-period counter at every bit boundary, so there is no cumulative drift.
REQ-023 SHALL drive busy = (state != IDLE) or (FIFO non-empty), registered.
REQ-024 SHALL send data bytes unmodified; no running-status or message parsing.

Reset
REQ-025 While reset=1, the block SHALL drive dout=1, busy=0, full=0, FIFO empty (pointers and count 0), FSM in IDLE, all counters 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame, with dout high on the next cycle; the abandoned and queued bytes are lost.
REQ-027 A wr_en pulse coincident with reset SHALL be ignored.

Structure
REQ-028 Package midi_pkg SHALL hold MIDI_BAUD (31250), the tx state enum type, and MIDI_DATA_WIDTH (8).
REQ-029 The buffer SHALL be the existing fifo sub-module (FIFO_DATA_WIDTH=8, FIFO_BUFFER_SIZE=FIFO_DEPTH), single-clock, wr_clk=rd_clk=clk.
REQ-030 The serializer FSM and baud counter SHALL reside in midi_tx; no further sub-modules.

Verification (CLK_FREQ=100, BAUD=10, so BIT_CYCLES=10, FIFO_DEPTH=4)
REQ-031 Write 0x90 at cycle 5:
  - dout low for cycles 7-16.
  - Then bits 0,0,0,0,1,0,0,1, 10 cycles each.
  - Then high for cycles 97-106.
  - busy falls at cycle 107.
REQ-032 Write 0x90, 0x3C, 0x7F on consecutive cycles:
  - Three frames back-to-back, 300 cycles total, with no high gap between stop and start.
  - A loopback midi_receiver outputs 0x90, 0x3C, 0x7F in order.
REQ-033 Write 6 bytes 0x01..0x06 on consecutive cycles while the first frame starts:
  - full asserts after the 5th write, because the first byte was already popped.
  - The 6th byte is dropped.
  - Exactly 0x01..0x05 are transmitted.
REQ-034 Assert reset for 1 cycle at cycle 40 of a 0xFF frame:
  - dout=1 and busy=0 from cycle 41.
  - Nothing further is transmitted.
  - A new write of 0x55 afterwards produces a clean frame.
REQ-035 Write 0x00 then 0xFF:
  - Line shows 9 low bit-periods (start + data) for 0x00, then stop.
  - 0xFF shows only the start bit low.
  - Every bit width is exactly 10 cycles.
